// File: rtl/zmod_adc_spi_pkg.sv
// Shared types and constants for the AD9648 3-wire SPI configuration controller.
// The frame builder forces W1W0 to 00 so every transfer is a single-byte access.
package zmod_adc_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int FRAME_BITS = 24;
    localparam int INSTR_BITS = 16;
    localparam int DATA_BITS  = 8;
    localparam int RW_BIT     = 23;
    localparam int ADDR_MSB   = 20;
    localparam int ADDR_LSB   = 8;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                     rd,
        input logic [ADDR_MSB-ADDR_LSB:0] addr,
        input logic [DATA_BITS-1:0]     data
    );
        logic [DATA_BITS-1:0] payload;
        if (rd) begin
            payload = {DATA_BITS{1'b0}};
        end else begin
            payload = data;
        end
        return {rd, 2'b00, addr, payload};
    endfunction

endpackage

// File: rtl/zmod_adc_spi_tick.sv
// SPI phase timer: emits a one-cycle strobe at the end of every CLK_DIV-cycle phase.
// Cleared to a full phase whenever a new frame starts or the block is reset.
module zmod_adc_spi_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 32'd1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // next phase count
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = RELOAD;
        end else if (en_i) begin
            if (cnt_q == 8'd0) begin
                cnt_d = RELOAD;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // phase counter register
    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign tick_o = en_i && (cnt_q == 8'd0);

endmodule

// File: rtl/zmod_adc_spi.sv
// AXI4-Stream to 3-wire SPI bridge for AD9648 register access.
// Reads release sdio for the data byte and return the captured byte on m_axis.
module zmod_adc_spi
    import zmod_adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [23:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_sdio_o,
    output logic        spi_sdio_t,
    input  logic        spi_sdio_i
);

    localparam logic [4:0] LAST_BIT   = 5'(FRAME_BITS - 1);
    localparam logic [4:0] LAST_INSTR = 5'(INSTR_BITS - 1);
    localparam logic [4:0] FIRST_DATA = 5'(INSTR_BITS);

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic [4:0]              bit_q, bit_d;
    logic                    sclk_q, sclk_d;
    logic                    cs_n_q, cs_n_d;
    logic                    sdio_t_q, sdio_t_d;
    logic                    rd_q, rd_d;
    logic [DATA_BITS-1:0]    rx_q, rx_d;
    logic [DATA_BITS-1:0]    mdata_q, mdata_d;
    logic                    mvalid_q, mvalid_d;
    logic                    accept_s;
    logic                    tick_s;
    logic                    unused_s;

    assign unused_s      = ^s_axis_tdata[22:21];
    assign s_axis_tready = (state_q == IDLE) && !mvalid_q && !areset;
    assign accept_s      = s_axis_tvalid && s_axis_tready;

    zmod_adc_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i  (aclk),
        .clr_i  (areset || accept_s),
        .en_i   (state_q != IDLE),
        .tick_o (tick_s)
    );

    // frame sequencing, shifting, capture and result hand-off
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bit_d    = bit_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        sdio_t_d = sdio_t_q;
        rd_d     = rd_q;
        rx_d     = rx_q;
        mdata_d  = mdata_q;
        mvalid_d = mvalid_q;
        if (mvalid_q && m_axis_tready) begin
            mvalid_d = 1'b0;
        end else begin
            mvalid_d = mvalid_q;
        end
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d  = SHIFT;
                    shreg_d  = build_frame(s_axis_tdata[RW_BIT],
                                           s_axis_tdata[ADDR_MSB:ADDR_LSB],
                                           s_axis_tdata[DATA_BITS-1:0]);
                    bit_d    = 5'd0;
                    sclk_d   = 1'b0;
                    cs_n_d   = 1'b0;
                    sdio_t_d = 1'b0;
                    rd_d     = s_axis_tdata[RW_BIT];
                    rx_d     = {DATA_BITS{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (tick_s) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        if (rd_q && (bit_q >= FIRST_DATA)) begin
                            rx_d = {rx_q[DATA_BITS-2:0], spi_sdio_i};
                        end else begin
                            rx_d = rx_q;
                        end
                    end else begin
                        sclk_d  = 1'b0;
                        shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                        if (bit_q == LAST_BIT) begin
                            state_d = HOLD;
                        end else begin
                            bit_d = bit_q + 5'd1;
                            // the ADC takes over sdio from the first data bit onward
                            if (rd_q && (bit_q == LAST_INSTR)) begin
                                sdio_t_d = 1'b1;
                            end else begin
                                sdio_t_d = sdio_t_q;
                            end
                        end
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            HOLD: begin
                if (tick_s) begin
                    state_d = GAP;
                    cs_n_d  = 1'b1;
                    if (rd_q) begin
                        mvalid_d = 1'b1;
                        mdata_d  = rx_q;
                    end else begin
                        mdata_d = mdata_q;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            GAP: begin
                if (tick_s) begin
                    state_d  = IDLE;
                    sdio_t_d = 1'b1;
                end else begin
                    state_d = GAP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= IDLE;
            shreg_q  <= {FRAME_BITS{1'b0}};
            bit_q    <= 5'd0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            sdio_t_q <= 1'b1;
            rd_q     <= 1'b0;
            rx_q     <= {DATA_BITS{1'b0}};
            mdata_q  <= {DATA_BITS{1'b0}};
            mvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bit_q    <= bit_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            sdio_t_q <= sdio_t_d;
            rd_q     <= rd_d;
            rx_q     <= rx_d;
            mdata_q  <= mdata_d;
            mvalid_q <= mvalid_d;
        end
    end

    assign spi_sclk      = sclk_q;
    assign spi_cs_n      = cs_n_q;
    assign spi_sdio_o    = shreg_q[FRAME_BITS-1];
    assign spi_sdio_t    = sdio_t_q;
    assign m_axis_tdata  = mdata_q;
    assign m_axis_tvalid = mvalid_q;

endmodule
